fetch_ref_chroma_pp: RTL and testbench

//  Parametrised ping-pong chroma reference window buffer between fetch DMA and MC.
//  Two banks, each holding separate U and V planes; the fetch side fills one bank while MC reads the other.

---
 rtl/fetch_ref_chroma_pp_if.sv | 44 ++++
 rtl/fetch_ref_chroma_pp.sv | 132 +++++++++++++
 tb/tb_fetch_ref_chroma_pp.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ref_chroma_pp_if.sv
// Fetch-DMA / MC side signal bundle for the ping-pong chroma window buffer.
// The DUT connects through the slave modport; the driving side uses master.
interface fetch_ref_chroma_pp_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROW_PIX     = 48,
  parameter int ROWS        = 48,
  parameter int OUT_PIX     = 8,
  parameter int Y_WIDTH     = 9
);
  localparam int AW = $clog2(ROWS);
  localparam int XW = $clog2(ROW_PIX);

  logic                             sys_start_i;
  logic [Y_WIDTH-1:0]               sys_total_y_i;
  logic [Y_WIDTH-1:0]               mc_cur_y_i;
  logic                             mc_rden_i;
  logic                             mc_sel_i;
  logic                             mc_ilv_i;
  logic [XW-1:0]                    mc_x_i;
  logic [AW-1:0]                    mc_y_i;
  logic [OUT_PIX*PIXEL_WIDTH-1:0]   mc_pel_o;
  logic                             mc_valid_o;
  logic                             ld_valid_i;
  logic [AW-1:0]                    ld_addr_i;
  logic [2*ROW_PIX*PIXEL_WIDTH-1:0] ld_data_i;
  logic                             ld_done_i;
  logic                             ld_ready_o;
  logic                             rd_ready_o;
  logic                             err_o;

  modport master (
    output sys_start_i, sys_total_y_i, mc_cur_y_i,
    output mc_rden_i, mc_sel_i, mc_ilv_i, mc_x_i, mc_y_i,
    output ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    input  mc_pel_o, mc_valid_o, ld_ready_o, rd_ready_o, err_o
  );

  modport slave (
    input  sys_start_i, sys_total_y_i, mc_cur_y_i,
    input  mc_rden_i, mc_sel_i, mc_ilv_i, mc_x_i, mc_y_i,
    input  ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    output mc_pel_o, mc_valid_o, ld_ready_o, rd_ready_o, err_o
  );
endinterface

// File: rtl/fetch_ref_chroma_pp.sv
// Ping-pong chroma (U/V) reference window buffer: fetch fills one bank,
// MC reads the other with row/column clamping and an optional UVUV mode.
module fetch_ref_chroma_pp #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROW_PIX     = 48,
  parameter int ROWS        = 48,
  parameter int OUT_PIX     = 8,
  parameter int PAD         = 8,
  parameter int Y_WIDTH     = 9
) (
  input  logic clk,
  input  logic rst,
  fetch_ref_chroma_pp_if.slave bus
);
  localparam int AW = $clog2(ROWS);
  localparam int XW = $clog2(ROW_PIX);
  localparam int RW = ROW_PIX * PIXEL_WIDTH;
  localparam int OW = OUT_PIX * PIXEL_WIDTH;

  localparam logic [AW-1:0] PAD_A  = AW'(PAD);
  localparam logic [AW-1:0] TOP_A  = AW'(ROWS - PAD);
  localparam logic [AW-1:0] BOT_A  = AW'(ROWS - PAD - 1);
  localparam logic [AW-1:0] MAX_A  = AW'(ROWS - 1);
  localparam logic [AW:0]   ROWS_A = (AW+1)'(ROWS);
  localparam logic [XW-1:0] XL_N   = XW'(ROW_PIX - OUT_PIX);
  localparam logic [XW-1:0] XL_I   = XW'(ROW_PIX - OUT_PIX/2);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} bank_st_e;

  bank_st_e        st_q [2];
  bank_st_e        st_d [2];
  logic            rot_q, rot_d;
  logic            err_q, err_d;
  logic            vld_q;
  logic [OW-1:0]   pel_q, pel_d;
  logic            lb, rb, we;
  logic [AW-1:0]   yr;
  logic [XW-1:0]   xr, xlim;
  logic [RW-1:0]   ru, rv, src;
  int              c;

  logic [RW-1:0] mem_u [2][ROWS];
  logic [RW-1:0] mem_v [2][ROWS];

  assign lb = ~rot_q;
  assign rb = rot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q <= 1'b0;
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      pel_q <= '0;
    end else begin
      rot_q <= rot_d;
      st_q  <= st_d;
      err_q <= err_d;
      vld_q <= bus.mc_rden_i;
      if (bus.mc_rden_i) pel_q <= pel_d;
    end
  end

  // Storage has no reset; only the load bank is ever written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_u[lb][bus.ld_addr_i] <= bus.ld_data_i[2*RW-1:RW];
      mem_v[lb][bus.ld_addr_i] <= bus.ld_data_i[RW-1:0];
    end
  end

  always_comb begin
    st_d  = st_q;
    rot_d = rot_q;
    err_d = 1'b0;
    we    = 1'b0;
    if (bus.ld_valid_i) begin
      if (st_q[lb] == FULL || {1'b0, bus.ld_addr_i} >= ROWS_A) begin
        err_d = 1'b1;
      end else begin
        we = 1'b1;
        if (st_q[lb] == EMPTY) st_d[lb] = LOADING;
      end
    end
    if (bus.ld_done_i) st_d[lb] = FULL;
    if (bus.sys_start_i) begin
      rot_d    = ~rot_q;
      st_d[rb] = EMPTY;
      if (st_q[lb] != FULL) err_d = 1'b1;
    end
  end

  always_comb begin
    yr = bus.mc_y_i;
    if (bus.mc_cur_y_i == {Y_WIDTH{1'b0}}) begin
      yr = (bus.mc_y_i < PAD_A) ? '0 : bus.mc_y_i - PAD_A;
    end else if (bus.mc_cur_y_i == bus.sys_total_y_i) begin
      yr = (bus.mc_y_i >= TOP_A) ? BOT_A : bus.mc_y_i;
    end else if (bus.mc_y_i > MAX_A) begin
      yr = MAX_A;
    end
    xlim = bus.mc_ilv_i ? XL_I : XL_N;
    xr   = (bus.mc_x_i > xlim) ? xlim : bus.mc_x_i;
  end

  // Sample 0 sits in the MSBs of both stored rows and the output beat.
  always_comb begin
    ru    = mem_u[rb][yr];
    rv    = mem_v[rb][yr];
    pel_d = '0;
    src   = '0;
    c     = 0;
    for (int i = 0; i < OUT_PIX; i++) begin
      if (bus.mc_ilv_i) begin
        c   = int'(xr) + i/2;
        src = (i % 2 == 1) ? rv : ru;
      end else begin
        c   = int'(xr) + i;
        src = bus.mc_sel_i ? rv : ru;
      end
      pel_d[(OUT_PIX-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] =
        src[(ROW_PIX-1-c)*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  assign bus.mc_pel_o   = pel_q;
  assign bus.mc_valid_o = vld_q;
  assign bus.err_o      = err_q;
  assign bus.ld_ready_o = (st_q[lb] != FULL);
  assign bus.rd_ready_o = (st_q[rb] == FULL);
endmodule

// File: tb/tb_fetch_ref_chroma_pp.sv
// Bench for fetch_ref_chroma_pp: scenario tasks with a queue of
// expected read beats popped as the DUT returns them.
module tb_fetch_ref_chroma_pp;
  localparam int PW = 8;
  localparam int RP = 48;
  localparam int NR = 48;
  localparam int OP = 8;

  typedef logic [OP*PW-1:0] pel_t;
  typedef logic [2*RP*PW-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  pel_t sbq[$];

  always #5 clk = ~clk;

  fetch_ref_chroma_pp_if bus ();

  fetch_ref_chroma_pp dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic pel_t pel_const(int v);
    pel_t p;
    for (int i = 0; i < OP; i++) p[(OP-1-i)*PW +: PW] = PW'(v);
    return p;
  endfunction

  function automatic pel_t pel_seq(int s);
    pel_t p;
    for (int i = 0; i < OP; i++) p[(OP-1-i)*PW +: PW] = PW'(s + i);
    return p;
  endfunction

  function automatic pel_t pel_ilv(int s);
    pel_t p;
    for (int i = 0; i < OP; i++)
      p[(OP-1-i)*PW +: PW] = PW'((i % 2 == 1) ? 100 + s + i/2 : s + i/2);
    return p;
  endfunction

  // mode 0: U=row, V=row+128; 1: U=col, V=col+100; 2: U=255-row, V=64+row
  function automatic row_t row_data(int mode, int r);
    row_t d;
    int u, v;
    for (int c = 0; c < RP; c++) begin
      case (mode)
        0: begin u = r; v = r + 128; end
        1: begin u = c; v = c + 100; end
        default: begin u = 255 - r; v = 64 + r; end
      endcase
      d[(2*RP-1-c)*PW +: PW] = PW'(u);
      d[(RP-1-c)*PW +: PW] = PW'(v);
    end
    return d;
  endfunction

  task automatic load_bank(int mode);
    for (int r = 0; r < NR; r++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_addr_i = 6'(r);
      bus.ld_data_i = row_data(mode, r);
      tick();
    end
    bus.ld_valid_i = 1'b0;
    bus.ld_done_i = 1'b1;
    tick();
    bus.ld_done_i = 1'b0;
  endtask

  task automatic issue_read(logic sel, logic ilv, int x, int y, int cur, int tot, pel_t e);
    bus.mc_rden_i = 1'b1;
    bus.mc_sel_i = sel;
    bus.mc_ilv_i = ilv;
    bus.mc_x_i = 6'(x);
    bus.mc_y_i = 6'(y);
    bus.mc_cur_y_i = 9'(cur);
    bus.sys_total_y_i = 9'(tot);
    sbq.push_back(e);
  endtask

  task automatic start_pulse;
    bus.sys_start_i = 1'b1;
    tick();
    bus.sys_start_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.sys_start_i = 0; bus.sys_total_y_i = 0; bus.mc_cur_y_i = 0;
    bus.mc_rden_i = 0; bus.mc_sel_i = 0; bus.mc_ilv_i = 0;
    bus.mc_x_i = 0; bus.mc_y_i = 0; bus.ld_valid_i = 0;
    bus.ld_addr_i = 0; bus.ld_data_i = '0; bus.ld_done_i = 0;
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (bus.mc_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid_err: valid=%b err=%b, want 0 0", bus.mc_valid_o, bus.err_o);
    end
    total++;
    if (bus.ld_ready_o !== 1'b1 || bus.rd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: ld=%b rd=%b, want 1 0", bus.ld_ready_o, bus.rd_ready_o);
    end
    total++;
    if (bus.mc_pel_o !== pel_t'(0)) begin
      bad++;
      $display("FAIL reset_pel: got %h want 0", bus.mc_pel_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    pel_t e;
    load_bank(0);
    total++;
    if (bus.ld_ready_o !== 1'b0 || bus.rd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL loaded_flags: ld=%b rd=%b, want 0 0", bus.ld_ready_o, bus.rd_ready_o);
    end
    start_pulse();
    total++;
    if (bus.rd_ready_o !== 1'b1 || bus.ld_ready_o !== 1'b1 || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL start_flags: rd=%b ld=%b err=%b, want 1 1 0",
               bus.rd_ready_o, bus.ld_ready_o, bus.err_o);
    end
    issue_read(0, 0, 3, 20, 5, 9, pel_const(20));
    tick();
    bus.mc_rden_i = 1'b0;
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    total++;
    if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
      bad++;
      $display("FAIL basic_read: valid=%b pel=%h, want 1 %h", bus.mc_valid_o, bus.mc_pel_o, e);
    end
    tick();
    total++;
    if (bus.mc_valid_o !== 1'b0 || bus.mc_pel_o !== e) begin
      bad++;
      $display("FAIL hold: valid=%b pel=%h, want 0 %h", bus.mc_valid_o, bus.mc_pel_o, e);
    end
  endtask

  task automatic test_row_clamp;
    int ys[9]   = '{4, 12, 45, 30, 40, 60, 20, 8, 47};
    int curs[9] = '{0, 0, 9, 9, 9, 5, 5, 0, 0};
    int sels[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exps[9] = '{0, 4, 39, 30, 39, 47, 148, 0, 39};
    pel_t e;
    for (int k = 0; k < 9; k++) begin
      issue_read(sels[k][0], 0, 3, ys[k], curs[k], 9, pel_const(exps[k]));
      tick();
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      total++;
      if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
        bad++;
        $display("FAIL row_clamp[%0d]: valid=%b pel=%h, want 1 %h",
                 k, bus.mc_valid_o, bus.mc_pel_o, e);
      end
    end
    bus.mc_rden_i = 1'b0;
    tick();
  endtask

  task automatic test_col_clamp;
    int xs[6]   = '{46, 46, 3, 0, 40, 41};
    int sels[6] = '{0, 0, 1, 0, 0, 0};
    int ilvs[6] = '{0, 1, 0, 1, 0, 0};
    pel_t exps[6];
    pel_t e;
    exps[0] = pel_seq(40); exps[1] = pel_ilv(44); exps[2] = pel_seq(103);
    exps[3] = pel_ilv(0);  exps[4] = pel_seq(40); exps[5] = pel_seq(40);
    load_bank(1);
    start_pulse();
    total++;
    if (bus.err_o !== 1'b0 || bus.rd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL col_start: err=%b rd=%b, want 0 1", bus.err_o, bus.rd_ready_o);
    end
    for (int k = 0; k < 6; k++) begin
      issue_read(sels[k][0], ilvs[k][0], xs[k], 10, 5, 9, exps[k]);
      tick();
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      total++;
      if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
        bad++;
        $display("FAIL col_clamp[%0d]: valid=%b pel=%h, want 1 %h",
                 k, bus.mc_valid_o, bus.mc_pel_o, e);
      end
    end
    bus.mc_rden_i = 1'b0;
    tick();
  endtask

  task automatic test_errors;
    pel_t e;
    start_pulse();
    total++;
    if (bus.err_o !== 1'b1 || bus.rd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL start_not_full: err=%b rd=%b, want 1 0", bus.err_o, bus.rd_ready_o);
    end
    tick();
    total++;
    if (bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_single_pulse: err=%b want 0", bus.err_o);
    end
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd50;
    bus.ld_data_i = row_data(0, 50);
    tick();
    bus.ld_valid_i = 1'b0;
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++;
      $display("FAIL bad_addr: err=%b want 1", bus.err_o);
    end
    bus.ld_done_i = 1'b1;
    tick();
    bus.ld_done_i = 1'b0;
    total++;
    if (bus.ld_ready_o !== 1'b0 || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL done_only: ld=%b err=%b, want 0 0", bus.ld_ready_o, bus.err_o);
    end
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd5;
    bus.ld_data_i = row_data(0, 5);
    tick();
    bus.ld_valid_i = 1'b0;
    total++;
    if (bus.err_o !== 1'b1) begin
      bad++;
      $display("FAIL write_full: err=%b want 1", bus.err_o);
    end
    start_pulse();
    total++;
    if (bus.err_o !== 1'b0 || bus.rd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL start_full: err=%b rd=%b, want 0 1", bus.err_o, bus.rd_ready_o);
    end
    issue_read(0, 0, 0, 5, 5, 9, pel_seq(0));
    tick();
    bus.mc_rden_i = 1'b0;
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    total++;
    if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
      bad++;
      $display("FAIL dropped_write: valid=%b pel=%h, want 1 %h", bus.mc_valid_o, bus.mc_pel_o, e);
    end
  endtask

  task automatic test_back_to_back;
    int ys[4]   = '{0, 17, 30, 47};
    int sels[4] = '{0, 0, 1, 0};
    int exps[4] = '{255, 238, 94, 208};
    pel_t e;
    int nbad = 0;
    for (int r = 0; r < NR; r++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_addr_i = 6'(r);
      bus.ld_data_i = row_data(2, r);
      issue_read(0, 0, 0, r, 5, 9, pel_seq(0));
      tick();
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) nbad++;
    end
    bus.ld_valid_i = 1'b0;
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL concurrent_reads: bad beats=%0d want 0", nbad);
    end
    bus.ld_done_i = 1'b1;
    issue_read(0, 0, 0, 2, 5, 9, pel_seq(0));
    tick();
    bus.ld_done_i = 1'b0;
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    total++;
    if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
      bad++;
      $display("FAIL read_at_done: valid=%b pel=%h, want 1 %h", bus.mc_valid_o, bus.mc_pel_o, e);
    end
    bus.sys_start_i = 1'b1;
    issue_read(0, 0, 0, 3, 5, 9, pel_seq(0));
    tick();
    bus.sys_start_i = 1'b0;
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    total++;
    if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e || bus.err_o !== 1'b0) begin
      bad++;
      $display("FAIL read_at_start: valid=%b pel=%h err=%b, want 1 %h 0",
               bus.mc_valid_o, bus.mc_pel_o, bus.err_o, e);
    end
    for (int k = 0; k < 4; k++) begin
      issue_read(sels[k][0], 0, 0, ys[k], 5, 9, pel_const(exps[k]));
      tick();
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      total++;
      if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
        bad++;
        $display("FAIL new_bank[%0d]: valid=%b pel=%h, want 1 %h",
                 k, bus.mc_valid_o, bus.mc_pel_o, e);
      end
    end
    bus.mc_rden_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    pel_t e;
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd0;
    bus.ld_data_i = row_data(0, 0);
    issue_read(0, 0, 0, 1, 5, 9, pel_const(0));
    tick();
    #2 rst = 1'b1;
    #1;
    void'(sbq.pop_front());
    total++;
    if (bus.mc_valid_o !== 1'b0 || bus.ld_ready_o !== 1'b1 ||
        bus.rd_ready_o !== 1'b0 || bus.mc_pel_o !== pel_t'(0)) begin
      bad++;
      $display("FAIL mid_reset: valid=%b ld=%b rd=%b pel=%h, want 0 1 0 0",
               bus.mc_valid_o, bus.ld_ready_o, bus.rd_ready_o, bus.mc_pel_o);
    end
    bus.ld_valid_i = 1'b0;
    bus.mc_rden_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i = 6'd0;
    bus.ld_data_i = row_data(0, 0);
    tick();
    bus.ld_valid_i = 1'b0;
    bus.ld_done_i = 1'b1;
    tick();
    bus.ld_done_i = 1'b0;
    start_pulse();
    issue_read(0, 0, 0, 0, 5, 9, pel_const(0));
    tick();
    bus.mc_rden_i = 1'b0;
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    total++;
    if (bus.mc_valid_o !== 1'b1 || bus.mc_pel_o !== e) begin
      bad++;
      $display("FAIL rotate_after_reset: valid=%b pel=%h, want 1 %h",
               bus.mc_valid_o, bus.mc_pel_o, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_clamp();
    test_col_clamp();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
